// File: rtl/sram_burst_arbiter.sv
// Two-requester burst arbiter in front of one single-port SRAM: IDLE arbitrates, BURST issues beats, DRAIN waits out reads.
// Build option SRAM_ARB_FIXED_PRIO_EN: requester 0 wins every tie and the round-robin pointer is removed.
module sram_burst_arbiter #(
   parameter int N_addr = 11,
   parameter int N_data = 32,
   parameter int N_cnt  = 8,
   parameter int RD_LAT = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            req_valid_i,
   input  logic [1:0]            req_we_i,
   input  logic [2*N_addr-1:0]   req_addr_i,
   input  logic [2*N_cnt-1:0]    req_len_i,
   input  logic [2*N_data-1:0]   req_wdata_i,
   output logic [1:0]            gnt_o,
   output logic [1:0]            wready_o,
   output logic [1:0]            rvalid_o,
   output logic [N_data-1:0]     rdata_o,
   output logic [1:0]            done_o,
   output logic [N_addr-1:0]     sram_addr_o,
   output logic [N_data-1:0]     sram_din_o,
   output logic                  sram_write_en_o,
   output logic                  sram_sense_en_o,
   input  logic [N_data-1:0]     sram_dout_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [N_cnt-1:0] BEAT_ONE = {{(N_cnt-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [1:0]          gnt_q, gnt_d;
   logic                gid_q, gid_d;
   logic                we_q, we_d;
   logic [N_addr-1:0]   base_q, base_d;
   logic [N_cnt-1:0]    len_q, len_d;
   logic [N_cnt-1:0]    beat_q, beat_d;
   logic [1:0]          done_q, done_d;
   logic [N_addr-1:0]   sram_addr_q, sram_addr_d;
   logic [N_data-1:0]   sram_din_q, sram_din_d;
   logic                sram_we_q, sram_we_d;
   logic                sram_se_q, sram_se_d;
   logic [RD_LAT:0]     pv_q, pv_d;
   logic [RD_LAT:0]     pid_q, pid_d;
   logic [RD_LAT:0]     plast_q, plast_d;
   logic [1:0]          rvalid_q, rvalid_d;
   logic [N_data-1:0]   rdata_q, rdata_d;
   logic                win;
   logic                last_beat;
   logic                issue_rd;
`ifndef SRAM_ARB_FIXED_PRIO_EN
   logic                rr_q, rr_d;   // id of the most recently granted requester
`endif

   always_comb begin
      win = ~req_valid_i[0];
`ifndef SRAM_ARB_FIXED_PRIO_EN
      if (&req_valid_i) win = ~rr_q;
`endif
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gid_d       = gid_q;
      we_d        = we_q;
      base_d      = base_q;
      len_d       = len_q;
      beat_d      = beat_q;
      done_d      = 2'b00;
      sram_addr_d = sram_addr_q;
      sram_din_d  = sram_din_q;
      sram_we_d   = 1'b0;
      sram_se_d   = 1'b0;
      issue_rd    = 1'b0;
      last_beat   = (beat_q == len_q);
`ifndef SRAM_ARB_FIXED_PRIO_EN
      rr_d        = rr_q;
`endif
      case (state_q)
         S_IDLE: begin
            // a held grant here marks the done cycle, which never arbitrates
            if (gnt_q != 2'b00) begin
               gnt_d = 2'b00;
            end else if (|req_valid_i) begin
               gid_d   = win;
               gnt_d   = win ? 2'b10 : 2'b01;
               we_d    = req_we_i[win];
               base_d  = win ? req_addr_i[2*N_addr-1:N_addr] : req_addr_i[N_addr-1:0];
               len_d   = win ? req_len_i[2*N_cnt-1:N_cnt] : req_len_i[N_cnt-1:0];
               beat_d  = '0;
               state_d = S_BURST;
`ifndef SRAM_ARB_FIXED_PRIO_EN
               rr_d    = win;
`endif
            end
         end
         S_BURST: begin
            sram_addr_d = base_q + N_addr'(beat_q);
            beat_d      = beat_q + BEAT_ONE;
            if (we_q) begin
               sram_din_d = gid_q ? req_wdata_i[2*N_data-1:N_data] : req_wdata_i[N_data-1:0];
               sram_we_d  = 1'b1;
            end else begin
               sram_se_d  = 1'b1;
               issue_rd   = 1'b1;
            end
            if (last_beat) begin
               if (we_q) begin
                  done_d  = gnt_q;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pv_q[RD_LAT] && plast_q[RD_LAT]) begin
               done_d  = gnt_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pv_d     = {pv_q[RD_LAT-1:0], issue_rd};
      pid_d    = {pid_q[RD_LAT-1:0], gid_q};
      plast_d  = {plast_q[RD_LAT-1:0], issue_rd & last_beat};
      rvalid_d = 2'b00;
      rdata_d  = rdata_q;
      if (pv_q[RD_LAT]) begin
         rvalid_d = pid_q[RD_LAT] ? 2'b10 : 2'b01;
         rdata_d  = sram_dout_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         gnt_q       <= 2'b00;
         gid_q       <= 1'b0;
         we_q        <= 1'b0;
         base_q      <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         done_q      <= 2'b00;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
         sram_we_q   <= 1'b0;
         sram_se_q   <= 1'b0;
         pv_q        <= '0;
         pid_q       <= '0;
         plast_q     <= '0;
         rvalid_q    <= 2'b00;
         rdata_q     <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         rr_q        <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gid_q       <= gid_d;
         we_q        <= we_d;
         base_q      <= base_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         done_q      <= done_d;
         sram_addr_q <= sram_addr_d;
         sram_din_q  <= sram_din_d;
         sram_we_q   <= sram_we_d;
         sram_se_q   <= sram_se_d;
         pv_q        <= pv_d;
         pid_q       <= pid_d;
         plast_q     <= plast_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         rr_q        <= rr_d;
`endif
      end
   end

   assign gnt_o           = gnt_q;
   assign wready_o        = (state_q == S_BURST && we_q) ? gnt_q : 2'b00;
   assign rvalid_o        = rvalid_q;
   assign rdata_o         = rdata_q;
   assign done_o          = done_q;
   assign sram_addr_o     = sram_addr_q;
   assign sram_din_o      = sram_din_q;
   assign sram_write_en_o = sram_we_q;
   assign sram_sense_en_o = sram_se_q;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Bench for sram_burst_arbiter: directed and random bursts checked cycle by cycle against timing rules and a memory model.
module tb_sram_burst_arbiter;
   localparam int NA = 11;
   localparam int ND = 32;
   localparam int NC = 8;
   localparam int RL = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_we;
   logic [2*NA-1:0]  req_addr;
   logic [2*NC-1:0]  req_len;
   logic [2*ND-1:0]  req_wdata;
   logic [1:0]       gnt, wready, rvalid, done;
   logic [ND-1:0]    rdata;
   logic [NA-1:0]    sram_addr;
   logic [ND-1:0]    sram_din;
   logic             sram_write_en, sram_sense_en;
   logic [ND-1:0]    sram_dout;

   logic [ND-1:0]    smem    [0:2047];
   logic [ND-1:0]    ref_mem [0:2047];
   logic [ND-1:0]    wbuf    [0:256];
   bit               loaded = 1'b0;
   bit               found;
   int               n_chk = 0;
   int               n_pass = 0;
   int               n_fail = 0;

   always #5 clk = ~clk;

   sram_burst_arbiter #(.N_addr(NA), .N_data(ND), .N_cnt(NC), .RD_LAT(RL)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_len_i(req_len), .req_wdata_i(req_wdata),
      .gnt_o(gnt), .wready_o(wready), .rvalid_o(rvalid), .rdata_o(rdata), .done_o(done),
      .sram_addr_o(sram_addr), .sram_din_o(sram_din),
      .sram_write_en_o(sram_write_en), .sram_sense_en_o(sram_sense_en),
      .sram_dout_i(sram_dout)
   );

   function automatic logic [ND-1:0] seed_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   // SRAM with one cycle of read latency
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 2048; i++) smem[i] = seed_word(i);
         loaded <= 1'b1;
      end else begin
         if (sram_write_en) smem[sram_addr] <= sram_din;
         if (sram_sense_en) sram_dout <= smem[sram_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_burst(input int r, input bit we, input int base, input int len,
                            input bit drop_mid, input bit rand_data);
      int         dk, t, wi;
      bit         got;
      logic [1:0] oh;
      oh = (r == 1) ? 2'b10 : 2'b01;
      dk = we ? len + 1 : len + 2 + RL;
      for (int b = 0; b <= len; b++) wbuf[b] = rand_data ? $urandom : 32'hA0 + b;
      wbuf[len+1] = $urandom;
      @(posedge clk); #1;
      req_valid[r]            = 1'b1;
      req_we[r]               = we;
      req_addr[r*NA +: NA]    = NA'(base);
      req_len[r*NC +: NC]     = NC'(len);
      req_wdata[r*ND +: ND]   = wbuf[0];
      got = 1'b0;
      t   = 0;
      while (!got && t < 20) begin
         @(negedge clk);
         if (gnt != 2'b00) got = 1'b1;
         else t++;
      end
      chk("grant_latency", t, 1);
      chk("grant_owner", gnt, oh);
      if (!got) return;
      for (int k = 0; k <= dk + 1; k++) begin
         if (k > 0) @(negedge clk);
         chk("gnt", gnt, (k <= dk) ? oh : 2'b00);
         chk("wready", wready, (we && k <= len) ? oh : 2'b00);
         chk("write_en", sram_write_en, we && k >= 1 && k <= len + 1);
         chk("sense_en", sram_sense_en, !we && k >= 1 && k <= len + 1);
         if (k >= 1 && k <= len + 1) begin
            chk("sram_addr", sram_addr, (base + k - 1) % 2048);
            if (we) chk("sram_din", sram_din, wbuf[k-1]);
         end
         chk("rvalid", rvalid, (!we && k >= 2 + RL && k <= dk) ? oh : 2'b00);
         if (!we && k >= 2 + RL && k <= dk)
            chk("rdata", rdata, ref_mem[(base + k - 2 - RL) % 2048]);
         chk("done", done, (k == dk) ? oh : 2'b00);
         @(posedge clk); #1;
         wi = (k + 1 > len + 1) ? len + 1 : k + 1;
         req_wdata[r*ND +: ND] = wbuf[wi];
         if (k == dk) req_valid[r] = 1'b0;
         if (drop_mid && k == 2) begin
            req_valid[r]         = 1'b0;
            req_we[r]            = ~we;
            req_addr[r*NA +: NA] = NA'($urandom);
            req_len[r*NC +: NC]  = NC'($urandom);
         end
      end
      if (we) for (int b = 0; b <= len; b++) ref_mem[(base + b) % 2048] = wbuf[b];
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 2'b00);
      chk({tag, "_wready"}, wready, 2'b00);
      chk({tag, "_rvalid"}, rvalid, 2'b00);
      chk({tag, "_done"}, done, 2'b00);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_sram_addr"}, sram_addr, 0);
      chk({tag, "_sram_din"}, sram_din, 0);
      chk({tag, "_write_en"}, sram_write_en, 0);
      chk({tag, "_sense_en"}, sram_sense_en, 0);
   endtask

   initial begin
      logic [1:0] exp_g;
      for (int i = 0; i < 2048; i++) ref_mem[i] = seed_word(i);
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      run_burst(0, 1'b1, 'h010, 3, 1'b0, 1'b0);
      run_burst(1, 1'b0, 'h010, 3, 1'b0, 1'b1);
      run_burst(1, 1'b0, 'h7FE, 3, 1'b0, 1'b1);
      run_burst(0, 1'b0, $urandom_range(0, 2047), 0, 1'b0, 1'b1);
      run_burst(0, 1'b1, $urandom_range(0, 2047), 5, 1'b1, 1'b1);
      for (int n = 0; n < 12; n++)
         run_burst($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 2047),
                   $urandom_range(0, 12), 1'b0, 1'b1);
      run_burst(1, 1'b1, 'h7F0, 255, 1'b0, 1'b1);
      run_burst(0, 1'b0, 'h7F0, 255, 1'b0, 1'b1);

      // reset in the middle of a len-7 write from requester 0
      @(posedge clk); #1;
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[NA-1:0] = 11'h123; req_len[NC-1:0] = 8'd7;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge clk);
         if (gnt != 2'b00) found = 1'b1;
      end
      chk("rst_test_grant", found, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = 2'b00;
      @(negedge clk);
      check_all_zero("midrst");
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         chk("midrst_no_done", done, 2'b00);
      end

      // both requesters hold back-to-back len-0 reads
      @(posedge clk); #1;
      req_we = 2'b00; req_len = '0;
      req_addr = {11'h055, 11'h044};
      req_valid = 2'b11;
      for (int g = 0; g < 4; g++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         exp_g = 2'b01;
`else
         exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
`endif
         found = 1'b0;
         for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clk);
            if (gnt != 2'b00) found = 1'b1;
         end
         chk("tie_found", found, 1);
         chk("tie_grant", gnt, exp_g);
         for (int t = 0; t < 30 && gnt != 2'b00; t++) @(negedge clk);
      end
      req_valid = 2'b00;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("final_idle_gnt", gnt, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sram_burst_arbiter.md
Name: sram_burst_arbiter

Overview:
- Shares one 32-bit-wide compiled SRAM array group between two requesters, e.g. the scan loader and the core fetch/LSU path.
- Each requester issues burst transactions as base address plus beat count, either read or write.
- The arbiter grants one requester at a time and sequences per-beat addresses, write_en, sense_en and data.
- It returns read data with a fixed pipeline latency and signals burst completion.

Parameters:
N_addr, 11, SRAM word-address width (matches addr10..addr0 of the array)
N_data, 32, data word width
N_cnt, 8, burst length field width; the burst has len+1 beats
RD_LAT, 1, cycles from sense_en cycle to valid sram_dout; legal range 1..4

Ports:
clk  in  1  single block clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester burst request; bit i is requester i
req_we  in  2  1 = write burst, 0 = read burst
req_addr  in  2*N_addr  base address; requester i uses [i*N_addr +: N_addr]
req_len  in  2*N_cnt  beats minus 1; packed as req_addr
req_wdata  in  2*N_data  write data of the current beat; packed
gnt  out  2  one-hot grant, held for the whole burst
wready  out  2  write beat accepted at this edge; requester advances wdata
rvalid  out  2  read beat valid on rdata
rdata  out  N_data  read data, shared by both requesters
done  out  2  1-cycle pulse at burst completion
sram_addr  out  N_addr  registered SRAM address
sram_din  out  N_data  registered SRAM write data
sram_write_en  out  1  registered write strobe
sram_sense_en  out  1  registered read strobe
sram_dout  in  N_data  SRAM read data

Behaviour:
- Reset: all outputs are 0, state is IDLE, round-robin pointer favours requester 0, and the read pipeline is flushed.
  - A reset mid-burst aborts the burst silently: no done, and in-flight rvalid is dropped.
- States are IDLE, BURST and DRAIN.
- IDLE:
  - If any req_valid is high, pick a winner and latch its addr, len and we.
  - gnt[winner] rises in the next cycle, called G, and the state moves to BURST with beat=0.
  - Arbitration happens only in IDLE; there is always at least one IDLE cycle between bursts.
- Round-robin: on a tie, the winner is the requester not most recently granted. A single requester always wins.
- BURST, write:
  - wready[w]=1 in cycles G..G+len.
  - At each such edge: sram_din<=req_wdata[w], sram_addr<=base+beat, sram_write_en<=1, beat++.
  - SRAM sees beat b in cycle G+b+1.
  - done[w] pulses in cycle G+len+1; the state goes directly to IDLE.
- BURST, read:
  - Identical sequencing, but with sram_sense_en<=1, sram_write_en<=0 and no wready.
  - After the last issue the state moves to DRAIN.
  - rdata<=sram_dout and rvalid[w]=1 in cycle G+b+2+RD_LAT.
  - done[w] is coincident with the last rvalid. DRAIN then returns to IDLE.
- sram_write_en and sram_sense_en are never both 1. Both are 0 outside issue cycles.
- sram_addr and sram_din hold their last values when idle.
- gnt stays high from G through the done cycle inclusive and drops the next cycle.
- Address arithmetic: base+beat is truncated to N_addr bits, so addresses wrap (0x7FF -> 0x000 for N_addr=11).
- Length limits: len=0 is a single beat; len=2^N_cnt-1 gives 2^N_cnt beats.
- Requests during a burst:
  - Dropping req_valid mid-burst does not abort it.
  - Changes to req_addr, req_len or req_we mid-burst are ignored because they are latched.
  - A requester must drop req_valid in the cycle after it sees done; otherwise that IDLE cycle sees a new request.
- Read pipeline: an RD_LAT+1-deep shift register carries the valid flag and requester id.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: ties are always won by requester 0, and the round-robin pointer is removed.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Req0 writes base 0x010, len 3, data 0xA0..0xA3 -> wready[0] in cycles G..G+3, SRAM writes 0x010..0x013, done[0] in cycle G+4, gnt[0] low at G+5.
- Req1 reads base 0x7FE, len 3, RD_LAT=1 -> sram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; rvalid[1] in cycles G+3..G+6 with preloaded data; done[1] in cycle G+6.
- Both requesters hold req_valid for back-to-back len-0 reads:
  - without the macro, grants alternate 0,1,0,1;
  - with SRAM_ARB_FIXED_PRIO_EN, requester 0 is granted every burst.
- Req0 read with len=0 while req1 is idle -> exactly one sense_en pulse, one rvalid[0] and one done[0]; write_en stays 0 throughout.
- rst asserted at beat 2 of a len-7 write -> the next cycle has all outputs 0 and state IDLE; no done; a subsequent tie grants requester 0.
- Req0 drops req_valid mid-burst (len 5) -> all 6 beats still issue and done[0] still pulses.
